// File: rtl/sha_blk_packer.sv
// sha_blk_packer: packs a word-serial stream into SHA-256 message blocks with a fill slot and an output slot.
// The fill slot can hold one completed block while the output slot waits for the core.
module sha_blk_packer #(
  parameter int DW   = 32,
  parameter int NW   = 16,
  parameter int CNTW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_start,
  input  logic                vld_i,
  input  logic [DW-1:0]       din_i,
  output logic                in_rdy,
  output logic                blk_vld,
  input  logic                blk_rdy,
  output logic [DW*NW-1:0]    blk_data,
  output logic                blk_init,
  output logic [CNTW-1:0]     blk_cnt,
  output logic                err_ovf,
  output logic                err_abort,
  input  logic                err_clr
);
  localparam int BW = DW*NW;
  localparam int WW = $clog2(NW);
  logic [BW-1:0]   r_fill, r_data;
  logic [WW-1:0]   r_wcnt;
  logic [CNTW-1:0] r_cnt;
  logic            r_init_pend, r_held, r_held_init, r_vld, r_init, r_ovf, r_abort;
  logic            w_take, w_free, w_acc, w_start, w_pend, w_done;
  logic [WW-1:0]   w_wc;
  logic [BW-1:0]   w_blk;
  always_comb begin
    w_take  = r_vld & blk_rdy;
    w_free  = !r_vld | w_take;
    w_acc   = vld_i & !r_held;
    w_start = msg_start & !r_held;
    w_wc    = w_start ? '0 : r_wcnt;
    w_pend  = r_init_pend | msg_start;
    w_done  = w_acc & (w_wc == WW'(NW-1));
    w_blk   = {r_fill[BW-DW-1:0], din_i};
  end
  // The held block keeps its own init flag so a msg_start during the hold only affects the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill      <= '0;
      r_data      <= '0;
      r_wcnt      <= '0;
      r_cnt       <= '0;
      r_init_pend <= 1'b0;
      r_held      <= 1'b0;
      r_held_init <= 1'b0;
      r_vld       <= 1'b0;
      r_init      <= 1'b0;
      r_ovf       <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_fill <= w_blk;
        r_wcnt <= w_wc + 1'b1;
      end else if (w_start) r_wcnt <= '0;
      r_init_pend <= w_done ? 1'b0 : w_pend;
      if (w_done && w_free) begin
        r_vld  <= 1'b1;
        r_data <= w_blk;
        r_init <= w_pend;
      end else if (w_take && r_held) begin
        r_data <= r_fill;
        r_init <= r_held_init;
        r_held <= 1'b0;
      end else if (w_take) r_vld <= 1'b0;
      if (w_done && !w_free) begin
        r_held      <= 1'b1;
        r_held_init <= w_pend;
      end
      if (w_take) r_cnt <= r_cnt + 1'b1;
      r_ovf   <= (vld_i & r_held) | (r_ovf & !err_clr);
      r_abort <= (w_start & (r_wcnt != '0)) | (r_abort & !err_clr);
    end
  end
  assign in_rdy    = !r_held;
  assign blk_vld   = r_vld;
  assign blk_data  = r_data;
  assign blk_init  = r_init;
  assign blk_cnt   = r_cnt;
  assign err_ovf   = r_ovf;
  assign err_abort = r_abort;
endmodule

// File: tb/tb_sha_blk_packer.sv
// tb_sha_blk_packer: scoreboard bench; expected blocks are queued as words are fed and popped on each handshake.
module tb_sha_blk_packer;
  localparam int DW = 32, NW = 16, CNTW = 8, BW = DW*NW;
  logic clk = 0, rst = 0, msg_start = 0, vld_i = 0, blk_rdy = 0, err_clr = 0;
  logic [DW-1:0] din_i = '0;
  logic in_rdy, blk_vld, blk_init, err_ovf, err_abort;
  logic [BW-1:0] blk_data;
  logic [CNTW-1:0] blk_cnt;
  int total = 0, bad = 0, n_hs = 0;
  logic [BW:0] sb[$];
  logic [BW:0] mon_exp;
  logic [DW-1:0] w[NW];
  logic [BW-1:0] blk;

  always #5 clk = ~clk;

  sha_blk_packer #(.DW(DW), .NW(NW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start), .vld_i(vld_i), .din_i(din_i),
    .in_rdy(in_rdy), .blk_vld(blk_vld), .blk_rdy(blk_rdy), .blk_data(blk_data),
    .blk_init(blk_init), .blk_cnt(blk_cnt), .err_ovf(err_ovf), .err_abort(err_abort),
    .err_clr(err_clr)
  );

  // Inputs change 1ns after posedge, so values seen at negedge are what the next posedge samples.
  always @(negedge clk) begin
    if (!rst && blk_vld && blk_rdy) begin
      n_hs++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_block got init=%0b data=%h", blk_init, blk_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({blk_init, blk_data} !== mon_exp) begin
          bad++;
          $display("FAIL block got=%h exp=%h", {blk_init, blk_data}, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [DW-1:0] d);
    vld_i = 1'b1;
    din_i = d;
    tick();
    vld_i = 1'b0;
  endtask

  task automatic pack();
    blk = '0;
    for (int i = 0; i < NW; i++) blk = {blk[BW-DW-1:0], w[i]};
  endtask

  task automatic rnd_blk();
    for (int i = 0; i < NW; i++) w[i] = $urandom;
    pack();
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) word(w[i]);
  endtask

  task automatic start();
    msg_start = 1'b1;
    tick();
    msg_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++;
    if ({in_rdy, blk_vld, blk_init, blk_cnt, err_ovf, err_abort} !== {3'b100, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {in_rdy, blk_vld, blk_init, blk_cnt, err_ovf, err_abort}, 13'b1_0000000000_00);
    end
    total++;
    if (blk_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", blk_data); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    blk_rdy = 1'b1;
    for (int i = 0; i < NW; i++) w[i] = DW'(i);
    pack();
    start();
    sb.push_back({1'b1, blk});
    feed(NW);
    total++;
    if (blk_vld !== 1'b1 || blk_cnt !== 8'd0) begin
      bad++;
      $display("FAIL basic_latency got vld=%b cnt=%0d exp vld=1 cnt=0", blk_vld, blk_cnt);
    end
    tick();
    total++;
    if (blk_vld !== 1'b0 || blk_cnt !== 8'd1) begin
      bad++;
      $display("FAIL basic_cnt got vld=%b cnt=%0d exp vld=0 cnt=1", blk_vld, blk_cnt);
    end
  endtask

  task automatic test_dbl_pattern();
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    w[8] = 32'h8000_0000;
    for (int i = 9; i < 15; i++) w[i] = '0;
    w[15] = 32'h0000_0100;
    pack();
    start();
    sb.push_back({1'b1, blk});
    feed(NW);
    drain();
    total++;
    if (blk_cnt !== 8'd2) begin bad++; $display("FAIL dbl_cnt got=%0d exp=2", blk_cnt); end
  endtask

  task automatic test_held();
    blk_rdy = 1'b0;
    start();
    rnd_blk();
    sb.push_back({1'b1, blk});
    feed(NW);
    total++;
    if (blk_vld !== 1'b1 || in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL held_first got vld=%b rdy=%b exp vld=1 rdy=1", blk_vld, in_rdy);
    end
    rnd_blk();
    sb.push_back({1'b0, blk});
    feed(NW);
    total++;
    if (in_rdy !== 1'b0) begin bad++; $display("FAIL held_rdy got=%b exp=0", in_rdy); end
    word(32'hDEAD_BEEF);
    total++;
    if (err_ovf !== 1'b1 || in_rdy !== 1'b0) begin
      bad++;
      $display("FAIL held_ovf got ovf=%b rdy=%b exp ovf=1 rdy=0", err_ovf, in_rdy);
    end
    blk_rdy = 1'b1;
    drain();
    total++;
    if (blk_cnt !== 8'd4 || in_rdy !== 1'b1 || blk_vld !== 1'b0) begin
      bad++;
      $display("FAIL held_drain got cnt=%0d rdy=%b vld=%b exp cnt=4 rdy=1 vld=0", blk_cnt, in_rdy, blk_vld);
    end
    rnd_blk();
    sb.push_back({1'b0, blk});
    feed(NW);
    drain();
    total++;
    if (blk_cnt !== 8'd5) begin bad++; $display("FAIL held_after got=%0d exp=5", blk_cnt); end
  endtask

  task automatic test_abort();
    blk_rdy = 1'b1;
    rnd_blk();
    feed(5);
    start();
    total++;
    if ({err_ovf, err_abort} !== 2'b11) begin
      bad++;
      $display("FAIL abort_flags got=%b exp=11", {err_ovf, err_abort});
    end
    rnd_blk();
    sb.push_back({1'b1, blk});
    feed(NW);
    rnd_blk();
    sb.push_back({1'b0, blk});
    feed(NW);
    drain();
    total++;
    if (blk_cnt !== 8'd7) begin bad++; $display("FAIL abort_cnt got=%0d exp=7", blk_cnt); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if ({err_ovf, err_abort} !== 2'b00) begin
      bad++;
      $display("FAIL clr_flags got=%b exp=00", {err_ovf, err_abort});
    end
    feed(3);
    msg_start = 1'b1;
    err_clr = 1'b1;
    tick();
    msg_start = 1'b0;
    err_clr = 1'b0;
    total++;
    if (err_abort !== 1'b1) begin bad++; $display("FAIL clr_vs_err got=%b exp=1", err_abort); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    blk_rdy = 1'b0;
    rnd_blk();
    sb.push_back({1'b1, blk});
    feed(NW);
    rnd_blk();
    sb.push_back({1'b0, blk});
    feed(NW-1);
    blk_rdy = 1'b1;
    word(w[NW-1]);
    total++;
    if (blk_vld !== 1'b1 || blk_data !== blk || blk_init !== 1'b0 || in_rdy !== 1'b1 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b got vld=%b init=%b rdy=%b ovf=%b data=%h exp data=%h", blk_vld, blk_init, in_rdy, err_ovf, blk_data, blk);
    end
    rnd_blk();
    sb.push_back({1'b1, blk});
    msg_start = 1'b1;
    vld_i = 1'b1;
    din_i = w[0];
    tick();
    msg_start = 1'b0;
    for (int i = 1; i < NW; i++) word(w[i]);
    drain();
    total++;
    if (blk_cnt !== 8'd10) begin bad++; $display("FAIL b2b_cnt got=%0d exp=10", blk_cnt); end
  endtask

  task automatic test_reset_mid();
    int hs0;
    blk_rdy = 1'b0;
    rnd_blk();
    feed(NW);
    feed(7);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_rdy, blk_vld, blk_init, blk_cnt, err_ovf, err_abort} !== {3'b100, 8'h00, 2'b00} || blk_data !== '0) begin
      bad++;
      $display("FAIL reset_mid got rdy=%b vld=%b cnt=%0d data=%h exp rdy=1 vld=0 cnt=0 data=0", in_rdy, blk_vld, blk_cnt, blk_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    blk_rdy = 1'b1;
    hs0 = n_hs;
    rnd_blk();
    sb.push_back({1'b0, blk});
    feed(NW);
    drain();
    repeat (3) tick();
    total++;
    if (n_hs - hs0 != 1 || blk_cnt !== 8'd1 || blk_vld !== 1'b0) begin
      bad++;
      $display("FAIL reset_one_blk got hs=%0d cnt=%0d vld=%b exp hs=1 cnt=1 vld=0", n_hs - hs0, blk_cnt, blk_vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dbl_pattern();
    test_held();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
